// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Package     : types_pkg
// Description : Shared node types. Instruction word, program counter, IROM
//               depth and the IROM loader state encoding.
// Revision    : 1.0 - initial release with loader state enum
// ============================================================================
package types_pkg;

  localparam int IROM_SIZE = 16;

  typedef logic [15:0] i_t;
  typedef logic [3:0]  pc_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    CHK  = 3'd2,
    FILL = 3'd3,
    DONE = 3'd4
  } ldr_state_t;

endpackage
`default_nettype wire

// File: rtl/irom_loader.sv
`default_nettype none
// ============================================================================
// Module      : irom_loader
// Description : Loads a length-prefixed, XOR-checksummed program from a
//               valid/ready byte stream into the node IROM. Words are built
//               little-endian, the unused tail is zero-filled, and the node is
//               held stalled for the whole load.
// Ports       : CLK, nRST      - clock, asynchronous active-low reset
//               rx_data/valid  - incoming stream byte and its qualifier
//               rx_ready       - loader accepts a byte (state decode only)
//               idata/iaddr    - registered IROM write data and address
//               iwen           - registered IROM write enable, 1 cycle/word
//               node_hold      - stall node, pc held at 0
//               done           - one-cycle pulse at the end of every load
//               err            - sticky bad-length / checksum error flag
// Revision    : 1.0 - initial release
// ============================================================================
module irom_loader
  import types_pkg::*;
#(
  parameter int IW    = $bits(i_t),
  parameter int DEPTH = IROM_SIZE,
  parameter int AW    = $bits(pc_t)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [IW-1:0] idata,
  output logic [AW-1:0] iaddr,
  output logic          iwen,
  output logic          node_hold,
  output logic          done,
  output logic          err
);

  localparam int BPI = (IW + 7) / 8;
  localparam int SW  = BPI * 8;
  localparam int BCW = (BPI > 1) ? $clog2(BPI) : 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPI - 1);
  localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);
  localparam logic [AW:0]    LAST_ADDR = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0]    END_ADDR  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    ADDR_ONE  = (AW + 1)'(1);
  localparam logic [7:0]     MAX_LEN   = 8'(DEPTH);

  ldr_state_t     r_state;
  ldr_state_t     w_state_nxt;

  // r_addr is one bit wider than iaddr so a full program can end at DEPTH.
  logic [AW:0]    r_addr;
  logic [AW:0]    r_n;
  logic [7:0]     r_csum;
  logic [SW-1:0]  r_shift;
  logic [BCW-1:0] r_bcnt;
  logic           r_err;
  logic           r_iwen;
  logic [AW-1:0]  r_iaddr;
  logic [IW-1:0]  r_idata;

  logic [SW-1:0]  w_shift_nxt;
  logic           w_accept;
  logic           w_word_end;
  logic           w_last_word;
  logic           w_len_bad;
  logic           w_csum_ok;

  // Decoded from state only, so it never depends on rx_valid.
  assign rx_ready = (r_state == IDLE) || (r_state == DATA) || (r_state == CHK);
  assign w_accept = rx_valid && rx_ready;

  // New byte enters at the top; after BPI bytes the first byte sits lowest.
  assign w_shift_nxt = (r_shift >> 8) | (SW'(rx_data) << (SW - 8));
  assign w_word_end  = (r_bcnt == LAST_BYTE);
  assign w_last_word = ((r_addr + ADDR_ONE) == r_n);
  assign w_len_bad   = (rx_data > MAX_LEN);
  assign w_csum_ok   = (rx_data == r_csum);

  assign idata = r_idata;
  assign iaddr = r_iaddr;
  assign iwen  = r_iwen;
  assign err   = r_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    node_hold   = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (w_len_bad)             w_state_nxt = FILL;
          else if (rx_data == 8'd0)  w_state_nxt = CHK;
          else                       w_state_nxt = DATA;
        end
      end
      DATA: begin
        node_hold = 1'b1;
        if (rx_valid && w_word_end && w_last_word) w_state_nxt = CHK;
      end
      CHK: begin
        node_hold = 1'b1;
        // A good full-depth program leaves nothing to fill.
        if (rx_valid) begin
          w_state_nxt = (w_csum_ok && (r_addr == END_ADDR)) ? DONE : FILL;
        end
      end
      FILL: begin
        node_hold = 1'b1;
        if (r_addr == LAST_ADDR) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_n     <= '0;
      r_addr  <= '0;
      r_csum  <= '0;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_err   <= 1'b0;
      r_iwen  <= 1'b0;
      r_iaddr <= '0;
      r_idata <= '0;
    end else begin
      r_iwen <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_n    <= rx_data[AW:0];
            r_csum <= rx_data;
            r_err  <= w_len_bad;
            r_addr <= '0;
            r_bcnt <= '0;
          end
        end
        DATA: begin
          if (w_accept) begin
            r_csum  <= r_csum ^ rx_data;
            r_shift <= w_shift_nxt;
            if (w_word_end) begin
              r_bcnt  <= '0;
              r_iwen  <= 1'b1;
              r_iaddr <= r_addr[AW-1:0];
              r_idata <= w_shift_nxt[IW-1:0];
              r_addr  <= r_addr + ADDR_ONE;
            end else begin
              r_bcnt <= r_bcnt + BCNT_ONE;
            end
          end
        end
        CHK: begin
          // On mismatch the fill restarts at 0 to wipe the partial program.
          if (w_accept && !w_csum_ok) begin
            r_err  <= 1'b1;
            r_addr <= '0;
          end
        end
        FILL: begin
          r_iwen  <= 1'b1;
          r_iaddr <= r_addr[AW-1:0];
          r_idata <= '0;
          r_addr  <= r_addr + ADDR_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_irom_loader
// Description : Self-checking bench for irom_loader. Frames are checked
//               against a frame-level model of the expected IROM write list,
//               error flag and load duration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irom_loader;

  localparam int IW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BPI   = (IW + 7) / 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [IW-1:0] idata;
  logic [AW-1:0] iaddr;
  logic          iwen;
  logic          node_hold;
  logic          done;
  logic          err;

  irom_loader #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .idata     (idata),
    .iaddr     (iaddr),
    .iwen      (iwen),
    .node_hold (node_hold),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Observed writes and pulses
  logic [31:0] wr_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int hold_bad = 0;
  bit busy = 1'b0;

  always @(negedge CLK) begin
    if (iwen) wr_q.push_back({12'd0, iaddr, idata});
    if (busy && !done && !node_hold) hold_bad++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (node_hold) hold_bad++;
    end
  end

  // Frame under test and its expected outcome
  logic [7:0]  frm[$];
  logic [31:0] exp_q[$];
  bit          exp_err;
  int          exp_fill;
  int          last_xfer;
  int          ready_hi;

  function automatic void build_expected();
    int n;
    logic [7:0] cs;
    logic [IW-1:0] word;
    exp_q.delete();
    n = int'(frm[0]);
    if (n > DEPTH) begin
      exp_err  = 1'b1;
      exp_fill = 0;
    end else begin
      cs = frm[0];
      for (int w = 0; w < n; w++) begin
        word = '0;
        for (int k = 0; k < BPI; k++) begin
          word = word | IW'(32'(frm[1 + BPI * w + k]) << (8 * k));
          cs   = cs ^ frm[1 + BPI * w + k];
        end
        exp_q.push_back({12'd0, 4'(w), word});
      end
      if (frm[frm.size() - 1] == cs) begin
        exp_err  = 1'b0;
        exp_fill = n;
      end else begin
        exp_err  = 1'b1;
        exp_fill = 0;
      end
    end
    for (int a = exp_fill; a < DEPTH; a++) exp_q.push_back({12'd0, 4'(a), 16'h0000});
  endfunction

  // Count of entries where observed writes from index 'start' differ from exp_q
  function automatic int q_diff(input int start);
    int d;
    d = 0;
    if (wr_q.size() - start != exp_q.size()) d++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i >= wr_q.size()) d++;
      else if (wr_q[start + i] !== exp_q[i]) d++;
    end
    return d;
  endfunction

  task automatic make_frame(input int n, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    frm.delete();
    frm.push_back(8'(n));
    cs = 8'(n);
    for (int i = 0; i < n * BPI; i++) begin
      b = 8'($urandom_range(255, 0));
      frm.push_back(b);
      cs = cs ^ b;
    end
    if (corrupt) cs = cs ^ 8'(1 << $urandom_range(7, 0));
    frm.push_back(cs);
  endtask

  // Called in the drive phase (#1 after a rising edge); returns in it.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!ok && n < 100) begin
      @(negedge CLK);
      if (rx_ready) begin
        @(posedge CLK);
        #1;
        last_xfer = cyc;
        busy      = 1'b1;
        ok        = 1'b1;
      end else begin
        n++;
      end
    end
    if (!ok) begin
      @(posedge CLK);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    ready_hi = 0;
    while (!ok && n < 200) begin
      @(negedge CLK);
      if (rx_ready) ready_hi++;
      if (done) begin
        ok       = 1'b1;
        busy     = 1'b0;
        rx_valid = 1'b0;
      end
      n++;
    end
    busy = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input int maxgap, output bit ok);
    bit b_ok;
    ok = 1'b1;
    foreach (frm[i]) begin
      send_byte(frm[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, b_ok);
      if (!b_ok) ok = 1'b0;
    end
    wait_done(b_ok);
    if (!b_ok) ok = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({rx_ready, iwen, node_hold, done, err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/wen/hold/done/err=%b want 10000",
               {rx_ready, iwen, node_hold, done, err});
    end
    checks++;
    if ({iaddr, idata} !== 20'd0) begin
      errors++;
      $display("FAIL reset_bus: got iaddr=%h idata=%h want 0/0", iaddr, idata);
    end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_good_load();
    bit ok;
    int s, d0, h0;
    frm = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    build_expected();
    s = wr_q.size(); d0 = done_cnt; h0 = hold_bad;
    run_frame(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL good_timeout: frame did not complete"); end
    checks++;
    if (q_diff(s) != 0 || wr_q[s] !== 32'h0000_1234 || wr_q[s + 1] !== 32'h0001_5678) begin
      errors++;
      $display("FAIL good_writes: got %0d writes first=%h, want 16 first=00001234", wr_q.size() - s, wr_q[s]);
    end
    checks++;
    if (err !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL good_status: got err=%b dones=%0d want 0/1", err, done_cnt - d0);
    end
    checks++;
    if (hold_bad - h0 != 0 || ready_hi != 0) begin
      errors++;
      $display("FAIL good_hold: got hold_gaps=%0d ready_in_fill=%0d want 0/0", hold_bad - h0, ready_hi);
    end
    checks++;
    if (done_cyc != last_xfer + DEPTH - 2) begin
      errors++;
      $display("FAIL good_latency: got done at +%0d want +%0d", done_cyc - last_xfer, DEPTH - 2);
    end
  endtask

  task automatic test_csum_err();
    bit ok;
    int s;
    frm = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B};
    build_expected();
    s = wr_q.size();
    run_frame(0, ok);
    checks++;
    if (!ok || q_diff(s) != 0 || exp_q.size() != 18) begin
      errors++;
      $display("FAIL csum_writes: got %0d writes ok=%b want 18", wr_q.size() - s, ok);
    end
    checks++;
    if (err !== 1'b1 || done_cyc != last_xfer + DEPTH) begin
      errors++;
      $display("FAIL csum_status: got err=%b done at +%0d want 1/+%0d", err, done_cyc - last_xfer, DEPTH);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    int s;
    frm = '{8'h00, 8'h00};
    build_expected();
    s = wr_q.size();
    run_frame(0, ok);
    checks++;
    if (!ok || q_diff(s) != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got %0d writes err=%b want 16/0", wr_q.size() - s, err);
    end
  endtask

  task automatic test_bad_len();
    bit ok, ok2;
    int s, h0;
    frm = '{8'h11};
    build_expected();
    s = wr_q.size(); h0 = hold_bad;
    send_byte(8'h11, 0, ok);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    wait_done(ok2);
    checks++;
    if (!ok || !ok2 || q_diff(s) != 0) begin
      errors++;
      $display("FAIL badlen_writes: got %0d writes want 16", wr_q.size() - s);
    end
    checks++;
    if (err !== 1'b1 || ready_hi != 0 || hold_bad - h0 != 0) begin
      errors++;
      $display("FAIL badlen_status: got err=%b ready_in_fill=%0d want 1/0", err, ready_hi);
    end
    checks++;
    if (done_cyc != last_xfer + DEPTH) begin
      errors++;
      $display("FAIL badlen_latency: got done at +%0d want +%0d", done_cyc - last_xfer, DEPTH);
    end
  endtask

  task automatic test_full();
    bit ok;
    int s;
    make_frame(DEPTH, 1'b0);
    build_expected();
    s = wr_q.size();
    run_frame(0, ok);
    checks++;
    if (!ok || q_diff(s) != 0) begin
      errors++;
      $display("FAIL full_writes: got %0d writes want %0d", wr_q.size() - s, DEPTH);
    end
    checks++;
    if (err !== 1'b0 || done_cyc != last_xfer) begin
      errors++;
      $display("FAIL full_done: got err=%b done at +%0d want 0/+0", err, done_cyc - last_xfer);
    end
  endtask

  task automatic test_gaps();
    bit ok1, ok2;
    int s1, s2, d0, dd;
    make_frame(int'($urandom_range(DEPTH, 1)), 1'b0);
    build_expected();
    s1 = wr_q.size();
    run_frame(0, ok1);
    s2 = wr_q.size(); d0 = done_cnt;
    run_frame(4, ok2);
    dd = 0;
    for (int i = 0; i < s2 - s1; i++) if (s2 + i >= wr_q.size() || wr_q[s2 + i] !== wr_q[s1 + i]) dd++;
    checks++;
    if (!ok1 || !ok2 || dd != 0 || wr_q.size() - s2 != s2 - s1) begin
      errors++;
      $display("FAIL gaps_vs_gapless: got %0d writes (%0d differ) want %0d", wr_q.size() - s2, dd, s2 - s1);
    end
    checks++;
    if (q_diff(s2) != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL gaps_model: got %0d writes dones=%0d want %0d/1", wr_q.size() - s2, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    int s;
    frm = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    for (int i = 0; i < 3; i++) send_byte(frm[i], 0, ok);
    s = wr_q.size();
    nRST = 1'b0;
    busy = 1'b0;
    #1;
    checks++;
    if ({rx_ready, iwen, node_hold, done, err} !== 5'b10000 || {iaddr, idata} !== 20'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got ctrl=%b iaddr=%h idata=%h want 10000/0/0",
               {rx_ready, iwen, node_hold, done, err}, iaddr, idata);
    end
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (wr_q.size() != s) begin
      errors++;
      $display("FAIL midrst_nowrite: got %0d writes want 0", wr_q.size() - s);
    end
    build_expected();
    s = wr_q.size();
    run_frame(0, ok);
    checks++;
    if (!ok || q_diff(s) != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_reload: got %0d writes err=%b want 16/0", wr_q.size() - s, err);
    end
  endtask

  task automatic test_random();
    bit ok;
    int s;
    for (int t = 0; t < 8; t++) begin
      make_frame(int'($urandom_range(DEPTH, 0)), ($urandom_range(3, 0) == 0));
      build_expected();
      s = wr_q.size();
      run_frame(2, ok);
      checks++;
      if (!ok || q_diff(s) != 0 || err !== exp_err) begin
        errors++;
        $display("FAIL random_%0d: got %0d writes err=%b want %0d/%b", t, wr_q.size() - s, err, exp_q.size(), exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_csum_err();
    test_zero_len();
    test_bad_len();
    test_full();
    test_gaps();
    test_reset_midload();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irom_loader.md
# irom_loader

Byte-stream programmer for a node's instruction memory. It accepts a length-prefixed, checksummed program over a valid/ready byte interface, assembles little-endian instruction words, and drives the IROM write port (`idata`/`iaddr`/`iwen`). It zero-fills the unused tail of the memory and holds the node stalled for the whole load. One instance sits beside each node's IROM, between the host/debug link and the write port.

## Interface
- `IW`, 16: instruction width in bits; equals `$bits(i_t)`.
- `DEPTH`, 16: IROM entries; equals `IROM_SIZE`.
- `AW`, 4: address width; equals `$bits(pc_t)`.
- `CLK`  in  1  clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte. A byte transfers when `rx_valid && rx_ready`.
- `idata`  out  IW  write data to the IROM.
- `iaddr`  out  AW  write address to the IROM.
- `iwen`  out  1  write enable, one cycle per word.
- `node_hold`  out  1  stalls the node and holds its pc at 0 while high.
- `done`  out  1  one-cycle pulse when a load completes, good or bad.
- `err`  out  1  sticky; set on a bad length or checksum mismatch.

## Operation
- `BPI = ceil(IW/8)` bytes per instruction, little-endian. Bits of the last byte above `IW` are ignored.
- Frame format: length byte `N`, then `N*BPI` instruction bytes, then one checksum byte.
- Checksum = XOR of the length byte and every instruction byte.
- States:
  - `IDLE`: `rx_ready=1`. Accepting a byte latches `N`, seeds `csum=N`, clears `err`, and sets `node_hold`.
    - `N>DEPTH` → set `err`, go `FILL` with start address 0. No further bytes are consumed.
    - `N==0` → `CHK`.
    - Otherwise → `DATA`.
  - `DATA`: `rx_ready=1`. Shift each byte into the word assembler and XOR it into `csum`.
    - On the BPI-th byte, register `idata`=word, `iaddr`=word index, `iwen=1`, and increment the index.
    - After word `N-1` → `CHK`.
  - `CHK`: `rx_ready=1`. Accept one byte.
    - Byte equals `csum` → `FILL` from address `N`.
    - Mismatch → set `err`, `FILL` from address 0, wiping the partial program.
  - `FILL`: `rx_ready=0`. One `iwen` per cycle with `idata=0`, addresses ascending through `DEPTH-1`.
    - Start address `DEPTH` (i.e. `N==DEPTH` with a good checksum) → zero writes.
    - Afterwards → `DONE`.
  - `DONE`: `done=1` and `node_hold=0` for one cycle. `rx_ready=0`. → `IDLE`.
- The address counter is `AW+1` bits wide so it can reach `DEPTH` without wrapping. `iaddr` takes the low `AW` bits.
- A program is never partially live. `node_hold` stays high from length acceptance until `DONE`.

## Timing
- Reset values: state `IDLE`, `rx_ready=1`, `iwen=0`, `iaddr=0`, `idata=0`, `node_hold=0`, `done=0`, `err=0`, `csum=0`.
- `rx_ready` is decoded from state only; it never depends on `rx_valid`.
- Write outputs are registered. `iwen` rises the cycle after the final byte of a word transfers, and the IROM commits at the following edge.
- Idle cycles (`rx_valid=0`) in `DATA`/`CHK` stall the loader indefinitely with all state held.
- `FILL` from address `a` lasts `DEPTH-a` cycles, then `DONE` lasts 1 cycle.
- Minimum frame with `rx_valid` held high: `1+N*BPI+1` transfer cycles, plus `FILL`, plus `DONE`.
- `nRST` mid-load: immediate return to reset values. No write is issued for a partially assembled word, and the IROM content is left as-is.
- A byte presented in `FILL`/`DONE` is not consumed. It is taken as a length byte once the loader returns to `IDLE`.

## Structure
- `types_pkg` gains the loader state enum `ldr_state_t` (`IDLE`, `DATA`, `CHK`, `FILL`, `DONE`).
- `i_t`, `pc_t` and `IROM_SIZE` stay in `types_pkg`. Parameter defaults are derived from them.
- Single module, no sub-module. The byte assembler is a shift register plus byte counter in the same block.

## Test plan
- Good load, IW=16: bytes `02 34 12 78 56 0A` (csum `02^34^12^78^56`=`0A`) → writes `1234`@0, `5678`@1, zeros @2..15, `done` pulse, `err=0`, and `node_hold` high throughout.
- Checksum error: same frame with final byte `0B` → after writes @0 and @1, 16 zero writes @0..15, then `done`, `err=1`.
- `N=0`: bytes `00 00` → 16 zero writes, `done`, `err=0`. Bad length: byte `11` → `err=1`, 16 zero writes, and `rx_ready=0` during `FILL`.
- Full program, `N=16` with valid checksum → 16 data writes, no `FILL` writes, `done` on the cycle after `CHK`, and `iaddr` never wraps.
- Random `rx_valid` gaps during `DATA` → identical write sequence to the gapless run, with no duplicate or dropped `iwen`.
- Assert `nRST` after 3 bytes of a frame → all outputs at reset values, no `iwen`. The next full frame loads correctly.
